// File: rtl/burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : burst_scheduler
// Brief    : Plays bursts of 2-bit IQ symbols from a registered-read RAM into
//            lms6_tx on periodic or manual triggers, over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module burst_scheduler #(
    parameter int ADDR_W   = 11,
    parameter int PERIOD_W = 24
) (
    input  logic                chipclock,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [ADDR_W-1:0]   burst_start,
    input  logic [ADDR_W:0]     burst_len,
    input  logic                manual_trig,
    input  logic                ovr_clear,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [1:0]          mem_data,
    output logic [23:0]         tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                burst_done,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] c_period_one = PERIOD_W'(1);
    localparam logic [ADDR_W-1:0]   c_addr_one   = ADDR_W'(1);
    localparam logic [ADDR_W:0]     c_rem_one    = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;

    logic                w_period_on;
    logic                w_ptrig;
    logic                w_trig;
    logic                w_fire;
    logic [23:0]         w_iq;

    assign w_period_on = enable && (period != '0);
    assign w_ptrig     = w_period_on && (cnt_q == period - c_period_one);
    assign w_trig      = (w_ptrig || manual_trig) && enable;
    assign w_fire      = (state_q == S_PLAY) && tx_ready;

    // A period shrunk below the running count wraps on the next edge.
    always_comb begin
        cnt_d = cnt_q + c_period_one;
        if (!w_period_on || (cnt_q >= period - c_period_one)) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        w_iq = 24'h000000;
        case (mem_data)
            2'b00:   w_iq = 24'h000000;
            2'b01:   w_iq = 24'h000fff;
            2'b10:   w_iq = 24'hfff000;
            default: w_iq = 24'hffffff;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        tx_valid    = 1'b0;
        mem_addr    = addr_q;
        case (state_q)
            S_IDLE: begin
                if (w_trig && (burst_len != '0)) begin
                    addr_d      = burst_start;
                    remaining_d = burst_len;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                tx_valid = 1'b1;
                if (w_fire) begin
                    // Present the next address now so its symbol lands next cycle.
                    mem_addr    = addr_q + c_addr_one;
                    addr_d      = addr_q + c_addr_one;
                    remaining_d = remaining_q - c_rem_one;
                    if (remaining_q == c_rem_one) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!enable && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign ovr_d   = (w_trig && busy) || (ovr_q && !ovr_clear);
    assign tx_data = tx_valid ? w_iq : 24'h000000;

    always_ff @(posedge chipclock) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
        end
    end

    assign burst_done = done_q;
    assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_scheduler
// Brief    : Directed and random stimulus for burst_scheduler, checked every
//            cycle against a burst-timeline model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_scheduler;

    localparam int ADDR_W   = 11;
    localparam int PERIOD_W = 24;
    localparam int DEPTH    = 2048;
    localparam int CAP      = 1100;

    logic                chipclock = 1'b0;
    logic                rst;
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic [ADDR_W-1:0]   burst_start;
    logic [ADDR_W:0]     burst_len;
    logic                manual_trig;
    logic                ovr_clear;
    logic [ADDR_W-1:0]   mem_addr;
    logic [1:0]          mem_data;
    logic [23:0]         tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                busy;
    logic                burst_done;
    logic                overrun;

    always #5 chipclock = ~chipclock;

    burst_scheduler #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) dut (
        .chipclock   (chipclock),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .manual_trig (manual_trig),
        .ovr_clear   (ovr_clear),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .burst_done  (burst_done),
        .overrun     (overrun)
    );

    logic [1:0] mem [0:DEPTH-1];
    always @(posedge chipclock) mem_data <= mem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] iq(input logic [1:0] s);
        case (s)
            2'b00:   return 24'h000000;
            2'b01:   return 24'h000fff;
            2'b10:   return 24'hfff000;
            default: return 24'hffffff;
        endcase
    endfunction

    // Burst timeline: one lead cycle after the trigger, then symbol idx of len.
    int m_cnt = 0;
    bit m_active = 1'b0;
    bit m_lead = 1'b0;
    bit m_done = 1'b0;
    bit m_ovr = 1'b0;
    int m_start = 0;
    int m_len = 0;
    int m_idx = 0;

    always @(negedge chipclock) begin : b_model
        bit          ev, fire, ptrig, trig;
        int          ea, n_cnt;
        logic [23:0] ed;
        ev   = m_active && !m_lead;
        ed   = ev ? iq(mem[(m_start + m_idx) % DEPTH]) : 24'h0;
        fire = ev && tx_ready;
        ea   = m_lead ? m_start : (m_start + m_idx + (fire ? 1 : 0)) % DEPTH;
        if (chk_on) begin
            check("tx_valid", 32'(tx_valid), 32'(ev));
            check("tx_data", 32'(tx_data), 32'(ed));
            check("busy", 32'(busy), 32'(m_active));
            check("burst_done", 32'(burst_done), 32'(m_done));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (m_active) check("mem_addr", 32'(mem_addr), 32'(ea));
        end
        if (!rst) begin
            m_cnt = 0; m_active = 0; m_lead = 0; m_idx = 0; m_done = 0; m_ovr = 0;
        end else begin
            ptrig  = enable && (period != 0) && (m_cnt == int'(period) - 1);
            trig   = enable && (ptrig || manual_trig);
            n_cnt  = (!enable || period == 0 || m_cnt >= int'(period) - 1) ? 0 : m_cnt + 1;
            m_ovr  = (trig && m_active) || (m_ovr && !ovr_clear);
            m_done = 1'b0;
            if (m_active) begin
                if (!enable) m_active = 1'b0;
                else if (m_lead) m_lead = 1'b0;
                else if (fire) begin
                    m_idx++;
                    if (m_idx == m_len) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (trig && burst_len != 0) begin
                m_active = 1'b1;
                m_lead   = 1'b1;
                m_start  = int'(burst_start);
                m_len    = int'(burst_len);
                m_idx    = 0;
            end
            m_cnt = n_cnt;
        end
    end

    logic        cap_v    [0:CAP-1];
    logic        cap_rdy  [0:CAP-1];
    logic        cap_done [0:CAP-1];
    logic        cap_busy [0:CAP-1];
    logic        cap_ovr  [0:CAP-1];
    logic [23:0] cap_d    [0:CAP-1];
    int          cap_addr [0:CAP-1];
    bit          en_base;

    task automatic tick();
        @(posedge chipclock);
        #1;
    endtask

    // Called at posedge+1; cycle 0 is the cycle that starts now.
    task automatic run(input int n, input int trig_a, input int trig_b, input int stall_lo,
                       input int stall_hi, input int rst_at, input int en_off_at, input int clr_at);
        for (int i = 0; i < n; i++) begin
            manual_trig = (i == trig_a) || (i == trig_b);
            tx_ready    = !(i >= stall_lo && i <= stall_hi);
            rst         = (i != rst_at);
            enable      = en_base && !(en_off_at >= 0 && i >= en_off_at);
            ovr_clear   = (i == clr_at);
            @(negedge chipclock);
            #1;
            cap_v[i] = tx_valid;  cap_rdy[i] = tx_ready; cap_done[i] = burst_done;
            cap_busy[i] = busy;   cap_ovr[i] = overrun;  cap_d[i] = tx_data;
            cap_addr[i] = int'(mem_addr);
            tick();
        end
        manual_trig = 1'b0;
        ovr_clear   = 1'b0;
        rst         = 1'b1;
    endtask

    function automatic int count_fires(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_v[i] && cap_rdy[i]) c++;
        return c;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_done[i]) c++;
        return c;
    endfunction

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_busy[i] || cap_v[i]) c++;
        return c;
    endfunction

    initial begin
        int held;
        rst = 1'b0; enable = 1'b0; period = '0; burst_start = '0; burst_len = '0;
        manual_trig = 1'b0; ovr_clear = 1'b0; tx_ready = 1'b1; en_base = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
        tick();
        chk_on = 1'b1;
        tick(); tick();
        rst = 1'b1;
        @(negedge chipclock);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset burst_done", 32'(burst_done), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        tick();

        // Periodic bursts, period 10, four symbols 1,2,3,0
        mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd0;
        period = 24'd10; burst_start = '0; burst_len = 12'd4; en_base = 1'b1;
        run(26, -1, -1, -1, -1, -1, -1, -1);
        check("t1 valid c10", 32'(cap_v[10]), 32'd0);
        check("t1 data c10", 32'(cap_d[10]), 32'd0);
        check("t1 valid c11", 32'(cap_v[11]), 32'd1);
        check("t1 data c11", 32'(cap_d[11]), 32'h000fff);
        check("t1 data c12", 32'(cap_d[12]), 32'hfff000);
        check("t1 data c13", 32'(cap_d[13]), 32'hffffff);
        check("t1 valid c14", 32'(cap_v[14]), 32'd1);
        check("t1 data c14", 32'(cap_d[14]), 32'h000000);
        check("t1 valid c15", 32'(cap_v[15]), 32'd0);
        check("t1 done c14", 32'(cap_done[14]), 32'd0);
        check("t1 done c15", 32'(cap_done[15]), 32'd1);
        check("t1 valid c21", 32'(cap_v[21]), 32'd1);
        check("t1 done c25", 32'(cap_done[25]), 32'd1);
        en_base = 1'b0;
        run(4, -1, -1, -1, -1, -1, -1, -1);

        // Stall on the second word for three cycles
        en_base = 1'b1;
        run(20, -1, -1, 12, 14, -1, -1, -1);
        held = 0;
        for (int i = 0; i < 20; i++) if (cap_v[i] && cap_d[i] == 24'hfff000) held++;
        check("t2 fff000 held cycles", 32'(held), 32'd4);
        check("t2 fires", 32'(count_fires(20)), 32'd4);
        check("t2 done c18", 32'(cap_done[18]), 32'd1);
        en_base = 1'b0;
        run(4, -1, -1, -1, -1, -1, -1, -1);

        // Address wrap inside a manual burst
        mem[2046] = 2'd2; mem[2047] = 2'd3;
        period = '0; burst_start = 11'd2046; burst_len = 12'd4; en_base = 1'b1;
        run(10, 0, -1, -1, -1, -1, -1, -1);
        check("t3 addr c1", 32'(cap_addr[1]), 32'd2046);
        check("t3 addr c2", 32'(cap_addr[2]), 32'd2047);
        check("t3 addr c3", 32'(cap_addr[3]), 32'd0);
        check("t3 addr c4", 32'(cap_addr[4]), 32'd1);
        check("t3 data c3", 32'(cap_d[3]), 32'hffffff);
        check("t3 fires", 32'(count_fires(10)), 32'd4);
        check("t3 done count", 32'(count_done(10)), 32'd1);

        // Trigger during play sets overrun without disturbing the burst
        burst_start = '0; burst_len = 12'd6;
        run(12, 0, 3, -1, -1, -1, -1, -1);
        check("t4 ovr c3", 32'(cap_ovr[3]), 32'd0);
        check("t4 ovr c4", 32'(cap_ovr[4]), 32'd1);
        check("t4 fires", 32'(count_fires(12)), 32'd6);
        check("t4 done c8", 32'(cap_done[8]), 32'd1);
        run(3, -1, -1, -1, -1, -1, -1, 0);
        check("t4 ovr before clear", 32'(cap_ovr[0]), 32'd1);
        check("t4 ovr after clear", 32'(cap_ovr[1]), 32'd0);

        // Zero length and periodic-off never start a burst
        burst_len = '0;
        run(6, 0, -1, -1, -1, -1, -1, -1);
        check("t5 len0 busy", 32'(count_busy(6)), 32'd0);
        check("t5 len0 done", 32'(count_done(6)), 32'd0);
        period = 24'd5;
        run(20, -1, -1, -1, -1, -1, -1, -1);
        check("t5 len0 periodic busy", 32'(count_busy(20)), 32'd0);
        period = '0; burst_len = 12'd3;
        run(1000, -1, -1, -1, -1, -1, -1, -1);
        check("t5 period0 busy", 32'(count_busy(1000)), 32'd0);

        // Reset in the second play cycle, then an enable drop mid-burst
        burst_len = 12'd6;
        run(8, 0, 2, -1, -1, 3, -1, -1);
        check("t6 ovr c3", 32'(cap_ovr[3]), 32'd1);
        check("t6 valid after rst", 32'(cap_v[4]), 32'd0);
        check("t6 data after rst", 32'(cap_d[4]), 32'd0);
        check("t6 busy after rst", 32'(cap_busy[4]), 32'd0);
        check("t6 ovr after rst", 32'(cap_ovr[4]), 32'd0);
        run(10, 0, -1, -1, -1, -1, 3, -1);
        check("t6 busy c3", 32'(cap_busy[3]), 32'd1);
        check("t6 busy after abort", 32'(cap_busy[4]), 32'd0);
        check("t6 no done on abort", 32'(count_done(10)), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
        period = 24'd17;
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 499) != 0);
            enable      = ($urandom_range(0, 99) != 0);
            manual_trig = ($urandom_range(0, 39) == 0);
            ovr_clear   = ($urandom_range(0, 29) == 0);
            tx_ready    = ($urandom_range(0, 3) != 0);
            burst_len   = 12'($urandom_range(0, 10));
            burst_start = 11'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 199) == 0) period = 24'($urandom_range(0, 40));
            tick();
        end
        rst = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
